mode_ctrl_bank: RTL

Parametrised multi-mode control register bank for the timer/counter display. Holds one 5-bit control word per display mode (59:59, 999.9, and further modes). Routes the front-panel buttons and switches to the word of the currently selected mode. Adds three things the single-shot capture stage lacked:
- input synchronisation;
- edge-detected toggle/pulse semantics;
- a registered active-mode word for the downstream counter datapath.

---
 rtl/mode_ctrl_pkg.sv | 23 ++
 rtl/sync_edge.sv | 33 +++
 rtl/mode_ctrl_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the multi-mode display control bank.
package mode_ctrl_pkg;

    localparam int unsigned CTRL_W     = 5;

    localparam int unsigned F_ENABLE   = 0;
    localparam int unsigned F_LOAD     = 1;
    localparam int unsigned F_CLEAR    = 2;
    localparam int unsigned F_COUNT_UP = 3;
    localparam int unsigned F_EN_BU    = 4;

    localparam int unsigned MODE_MMSS  = 0;
    localparam int unsigned MODE_DECI  = 1;

    typedef struct packed {
        logic en_bu;
        logic count_up;
        logic clear;
        logic load;
        logic enable;
    } ctrl_word_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a history flop; exposes level, history and rising edge.
module sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] level,
    output logic [W-1:0] hist,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign hist   = s3;
    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/mode_ctrl_bank.sv
// Per-mode control word bank: synchronised buttons/switches update the word of the
// accepted mode; exposes all words plus a registered copy of the active one.
module mode_ctrl_bank
    import mode_ctrl_pkg::*;
#(
    parameter int unsigned N_MODES = 2,
    parameter int unsigned MODE_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MODE_W-1:0]          mode_sel,
    input  logic                       btn_enable,
    input  logic                       btn_load,
    input  logic                       btn_clear,
    input  logic                       sw_count_up,
    input  logic                       sw_en_bu,
    output logic [CTRL_W*N_MODES-1:0]  states,
    output logic [CTRL_W-1:0]          active_word,
    output logic [MODE_W-1:0]          mode_q,
    output logic                       mode_change
);

    logic              en_rise_c;
    logic              ld_rise_c;
    logic              clr_rise_c;
    logic [1:0]        sw_lvl;
    logic [MODE_W-1:0] mode_lvl;
    logic [MODE_W-1:0] mode_hist;

    logic              unused_en_lvl, unused_en_hist;
    logic              unused_ld_lvl, unused_ld_hist;
    logic              unused_clr_lvl, unused_clr_hist;
    logic [1:0]        unused_sw_hist, unused_sw_rise;
    logic [MODE_W-1:0] unused_mode_rise;

    sync_edge #(.W(1)) u_sync_enable (
        .clk(clk), .rst_n(rst_n), .d(btn_enable),
        .level(unused_en_lvl), .hist(unused_en_hist), .rise_c(en_rise_c)
    );

    sync_edge #(.W(1)) u_sync_load (
        .clk(clk), .rst_n(rst_n), .d(btn_load),
        .level(unused_ld_lvl), .hist(unused_ld_hist), .rise_c(ld_rise_c)
    );

    sync_edge #(.W(1)) u_sync_clear (
        .clk(clk), .rst_n(rst_n), .d(btn_clear),
        .level(unused_clr_lvl), .hist(unused_clr_hist), .rise_c(clr_rise_c)
    );

    sync_edge #(.W(2)) u_sync_sw (
        .clk(clk), .rst_n(rst_n), .d({sw_en_bu, sw_count_up}),
        .level(sw_lvl), .hist(unused_sw_hist), .rise_c(unused_sw_rise)
    );

    sync_edge #(.W(MODE_W)) u_sync_mode (
        .clk(clk), .rst_n(rst_n), .d(mode_sel),
        .level(mode_lvl), .hist(mode_hist), .rise_c(unused_mode_rise)
    );

    ctrl_word_t        words_q   [N_MODES];
    ctrl_word_t        words_nxt [N_MODES];
    ctrl_word_t        word_nxt;
    logic [MODE_W-1:0] mode_nxt;
    logic              accept_c;

    // Next-state: mode acceptance, then selected-word update (suppressed on a mode change).
    always_comb begin
        accept_c = (mode_lvl != mode_hist) && (mode_lvl != mode_q)
                   && (32'(mode_lvl) < N_MODES);
        mode_nxt = accept_c ? mode_lvl : mode_q;
        word_nxt = '0;

        for (int unsigned m = 0; m < N_MODES; m++) begin
            words_nxt[m]       = words_q[m];
            words_nxt[m].load  = 1'b0;
            words_nxt[m].clear = 1'b0;
            if (!accept_c && (MODE_W'(m) == mode_q)) begin
                words_nxt[m].enable   = words_q[m].enable ^ en_rise_c;
                words_nxt[m].load     = ld_rise_c;
                words_nxt[m].clear    = clr_rise_c;
                words_nxt[m].count_up = sw_lvl[0];
                words_nxt[m].en_bu    = sw_lvl[1];
            end
        end

        for (int unsigned m = 0; m < N_MODES; m++) begin
            if (MODE_W'(m) == mode_nxt) begin
                word_nxt = words_nxt[m];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned m = 0; m < N_MODES; m++) begin
                words_q[m] <= '0;
            end
            mode_q      <= '0;
            active_word <= '0;
            mode_change <= 1'b0;
        end else begin
            for (int unsigned m = 0; m < N_MODES; m++) begin
                words_q[m] <= words_nxt[m];
            end
            mode_q      <= mode_nxt;
            active_word <= word_nxt;
            mode_change <= accept_c;
        end
    end

    for (genvar g = 0; g < int'(N_MODES); g++) begin : g_flat
        assign states[g*CTRL_W +: CTRL_W] = words_q[g];
    end

endmodule
